set_cmd_sched: RTL and testbench

Command scheduler in front of the single SET candidate-counting engine. It accepts set-counting commands (three circle centres, three radii, mode) from NREQ independent requesters and arbitrates among them round-robin. It issues one command at a time to the engine through its `en`/`central`/`radius`/`mode` inputs, then routes the engine's `valid`/`candidate` result back tagged with the requester index. A watchdog recovers from an engine that never answers.

---
 rtl/set_cmd_sched.sv | 131 +++++++++++++
 tb/tb_set_cmd_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/set_cmd_sched.sv
// Round-robin command scheduler in front of the single SET candidate-counting engine.
// One command in flight at a time; results return tagged with the requester index.
module set_cmd_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [24*NREQ-1:0]   req_central,
  input  logic [12*NREQ-1:0]   req_radius,
  input  logic [2*NREQ-1:0]    req_mode,
  output logic [NREQ-1:0]      req_ready,
  output logic                 eng_en,
  output logic [23:0]          eng_central,
  output logic [11:0]          eng_radius,
  output logic [1:0]           eng_mode,
  input  logic                 eng_valid,
  input  logic [7:0]           eng_candidate,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_candidate,
  output logic                 rsp_err,
  output logic                 sched_busy
);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WMAX = WDW'(TIMEOUT - 1);

  typedef struct packed {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, nxt;
  cmd_t               cmd, sel;
  logic [IDW-1:0]     rr_ptr, rr_nxt, grant, cur_id;
  logic [WDW-1:0]     wdog;
  logic [2*NREQ-1:0]  rot;
  logic               found, xfer, done;

  // Rotate the request vector so that rr_ptr lands at bit 0, then pick the lowest set bit.
  always_comb begin
    int j;
    rot   = {req_valid, req_valid} >> rr_ptr;
    found = 1'b0;
    grant = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        j     = int'(rr_ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        grant = IDW'(j);
      end
    end
  end

  always_comb begin
    sel       = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel.central = req_central[24*i +: 24];
        sel.radius  = req_radius[12*i +: 12];
        sel.mode    = req_mode[2*i +: 2];
      end
      req_ready[i] = (state == IDLE) && found && (grant == IDW'(i));
    end
  end

  assign xfer   = (state == IDLE) && found;
  assign rr_nxt = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
  // eng_valid takes priority over a simultaneous watchdog expiry.
  assign done   = (state == WAIT) && (eng_valid || wdog == WMAX);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (found) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (done) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cmd           <= '0;
      cur_id        <= '0;
      rr_ptr        <= '0;
      wdog          <= '0;
      eng_en        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_candidate <= '0;
      rsp_err       <= 1'b0;
      sched_busy    <= 1'b0;
    end else begin
      state      <= nxt;
      eng_en     <= xfer;
      rsp_valid  <= done;
      sched_busy <= (nxt != IDLE);
      if (xfer) begin
        cmd    <= sel;
        cur_id <= grant;
        rr_ptr <= rr_nxt;
      end
      if (state == WAIT) begin
        if (wdog != WMAX) wdog <= wdog + WDW'(1);
      end else begin
        wdog <= '0;
      end
      if (done) begin
        rsp_id        <= cur_id;
        rsp_candidate <= eng_valid ? eng_candidate : 8'd0;
        rsp_err       <= ~eng_valid;
      end
    end
  end

  // Engine inputs stay stable from ISSUE until the next accepted command.
  assign eng_central = cmd.central;
  assign eng_radius  = cmd.radius;
  assign eng_mode    = cmd.mode;
endmodule

// File: tb/tb_set_cmd_sched.sv
// Directed bench for set_cmd_sched: vector table of single commands plus
// hand-written round-robin, stray-strobe and reset-mid-WAIT sequences.
module tb_set_cmd_sched;
  localparam int NREQ = 4, IDW = 3, TIMEOUT = 512;

  logic                clk = 1'b0, rst = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [24*NREQ-1:0]  req_central;
  logic [12*NREQ-1:0]  req_radius;
  logic [2*NREQ-1:0]   req_mode;
  logic [NREQ-1:0]     req_ready;
  logic                eng_en, eng_valid = 1'b0;
  logic [23:0]         eng_central;
  logic [11:0]         eng_radius;
  logic [1:0]          eng_mode;
  logic [7:0]          eng_candidate = '0;
  logic                rsp_valid, rsp_err, sched_busy;
  logic [IDW-1:0]      rsp_id;
  logic [7:0]          rsp_candidate;

  set_cmd_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_central(req_central), .req_radius(req_radius),
    .req_mode(req_mode), .req_ready(req_ready),
    .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
    .eng_valid(eng_valid), .eng_candidate(eng_candidate),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_candidate(rsp_candidate),
    .rsp_err(rsp_err), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0, last_v = -100;

  typedef struct {
    logic [3:0] rv;
    int         dly;     // WAIT cycles before eng_valid; -1 = engine silent
    logic [7:0] cand;
    int         exp_id;
    logic       exp_err;
    logic [7:0] exp_cand;
  } vec_t;

  function automatic logic [23:0] cen(input int i);
    case (i)
      0: return 24'h234567;
      1: return 24'hABCDEF;
      2: return 24'h13579B;
      default: return 24'hFEDCBA;
    endcase
  endfunction
  function automatic logic [11:0] rad(input int i);
    case (i)
      0: return 12'h333;
      1: return 12'h7A5;
      2: return 12'h0F0;
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Called in the cycle where req_ready was observed; acts as the engine model.
  task automatic serve(input int dly, input logic [7:0] cand, input int id, input logic err,
                       input logic [7:0] ecand, input bit hold, input bit gap);
    int c0, exp_c;
    bit got;
    c0 = cyc;
    step();
    if (!hold) req_valid = '0;
    chk("eng_en_pulse", eng_en, 1);
    if (gap) chk("eng_en_gap", cyc - last_v, 3);
    chk("eng_central", eng_central, cen(id));
    chk("eng_radius", eng_radius, rad(id));
    chk("eng_mode", eng_mode, id[1:0]);
    chk("busy_issue", sched_busy, 1);
    step();
    chk("eng_en_single", eng_en, 0);
    got = 1'b0;
    for (int k = 0; k < TIMEOUT + 8; k++) begin
      if (k == dly) begin
        eng_valid     = 1'b1;
        eng_candidate = cand;
        last_v        = cyc;
      end
      step();
      eng_valid     = 1'b0;
      eng_candidate = '0;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("rsp_seen", got, 1);
    exp_c = (dly >= 0 && dly < TIMEOUT) ? c0 + 3 + dly : c0 + 2 + TIMEOUT;
    chk("rsp_cycle", cyc, exp_c);
    chk("rsp_id", rsp_id, id);
    chk("rsp_candidate", rsp_candidate, ecand);
    chk("rsp_err", rsp_err, err);
    step();
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("busy_idle", sched_busy, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_eng_en"}, eng_en, 0);
    chk({nm, "_eng_central"}, eng_central, 0);
    chk({nm, "_eng_radius"}, eng_radius, 0);
    chk({nm, "_eng_mode"}, eng_mode, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_id"}, rsp_id, 0);
    chk({nm, "_rsp_candidate"}, rsp_candidate, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_busy"}, sched_busy, 0);
    chk({nm, "_req_ready"}, req_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vec_t tab[8];
    bit   ok;
    for (int i = 0; i < NREQ; i++) begin
      req_central[24*i +: 24] = cen(i);
      req_radius[12*i +: 12]  = rad(i);
      req_mode[2*i +: 2]      = 2'(i);
    end
    tab[0] = '{4'b0001, 389,          8'd21,  0, 1'b0, 8'd21};
    tab[1] = '{4'b1000, 5,            8'd7,   3, 1'b0, 8'd7};
    tab[2] = '{4'b0010, 0,            8'd9,   1, 1'b0, 8'd9};
    tab[3] = '{4'b0011, 3,            8'h55,  0, 1'b0, 8'h55};
    tab[4] = '{4'b0110, -1,           8'hEE,  1, 1'b1, 8'h00};
    tab[5] = '{4'b0100, 2,            8'hAA,  2, 1'b0, 8'hAA};
    tab[6] = '{4'b1111, TIMEOUT - 1,  8'h3C,  3, 1'b0, 8'h3C};
    tab[7] = '{4'b1111, TIMEOUT - 2,  8'hFF,  0, 1'b0, 8'hFF};

    repeat (3) step();
    chk_zero("reset");
    rst = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      req_valid = tab[i].rv;
      wait_grant(ok);
      chk("grant_seen", ok, 1);
      chk("req_ready", req_ready, 1 << tab[i].exp_id);
      if (ok) serve(tab[i].dly, tab[i].cand, tab[i].exp_id, tab[i].exp_err, tab[i].exp_cand, 1'b0, 1'b0);
      req_valid = '0;
    end

    // stray eng_valid while idle
    eng_valid = 1'b1; eng_candidate = 8'h77;
    step();
    eng_valid = 1'b0; eng_candidate = '0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_no_rsp", rsp_valid, 0);
      step();
    end

    // reset in the middle of WAIT
    rst = 1'b0; step(); rst = 1'b1; step();
    req_valid = 4'b0100;
    wait_grant(ok);
    chk("mid_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    repeat (3) step();
    chk("mid_busy_before", sched_busy, 1);
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    step(); step();
    rst = 1'b1;
    eng_valid = 1'b1; eng_candidate = 8'h99;
    step();
    eng_valid = 1'b0; eng_candidate = '0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_rsp", rsp_valid, 0);
      step();
    end
    req_valid = 4'b1111;
    wait_grant(ok);
    chk("midrst_rr_ptr0", req_ready, 4'b0001);
    if (ok) serve(4, 8'h42, 0, 1'b0, 8'h42, 1'b0, 1'b0);
    req_valid = '0;

    // round robin with every requester held high from reset
    rst = 1'b0;
    req_valid = 4'b1111;
    step(); step();
    rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(ok);
      chk("rr_grant", req_ready, 1 << (n % 4));
      if (ok) serve(2, 8'(n + 1), n % 4, 1'b0, 8'(n + 1), 1'b1, n > 0);
    end
    req_valid = '0;
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
